// File: rtl/rr_mux4_arbiter_if.sv
// Handshake and data bundle between four producer lanes, the arbiter and one consumer.
interface rr_mux4_arbiter_if #(
    parameter int unsigned BIT = 4
);
    logic [3:0]     req;
    logic [BIT-1:0] in0;
    logic [BIT-1:0] in1;
    logic [BIT-1:0] in2;
    logic [BIT-1:0] in3;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [BIT-1:0] out;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     xfer_cnt;

    // Producers and consumer side
    modport master (
        output req, in0, in1, in2, in3, out_ready,
        input  gnt, sel, out, out_valid, xfer_cnt
    );

    // Arbiter side
    modport slave (
        input  req, in0, in1, in2, in3, out_ready,
        output gnt, sel, out, out_valid, xfer_cnt
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 arbiter with a one-deep registered valid/ready output stage.
module rr_mux4_arbiter #(
    parameter int unsigned BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    rr_mux4_arbiter_if.slave bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   sel_d;
    logic [BIT-1:0]     out_q;
    logic [BIT-1:0]     out_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [BIT-1:0]     lane_data [LANES];
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   win;
    logic               any_req;
    logic               out_valid;
    logic               can_take;
    logic [LANES-1:0]   gnt_c;

    assign lane_data[0] = bus.in0;
    assign lane_data[1] = bus.in1;
    assign lane_data[2] = bus.in2;
    assign lane_data[3] = bus.in3;

    assign out_valid = (state_q == HOLD);
    assign any_req   = |bus.req;
    assign can_take  = (!out_valid || bus.out_ready) && any_req && !reset;

    // Rotating priority search: first requesting lane at or after ptr wins
    always_comb begin
        win      = '0;
        scan_idx = '0;
        for (int unsigned i = LANES; i > 0; i--) begin
            scan_idx = ptr_q + IDX_W'(i - 1);
            if (bus.req[scan_idx]) begin
                win = scan_idx;
            end
        end
    end

    assign gnt_c = can_take ? (LANES'(1) << win) : '0;

    // Next-state and datapath load decisions
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        if (out_valid && bus.out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (can_take) begin
            out_d   = lane_data[win];
            sel_d   = win;
            ptr_d   = win + IDX_W'(1);
            state_d = HOLD;
        end else if (out_valid && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    // State and output-stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid;
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed and randomized checks of rr_mux4_arbiter against a behavioural model.
module tb_rr_mux4_arbiter;
    logic clk;
    logic reset;

    rr_mux4_arbiter_if #(.BIT(4)) bus ();

    rr_mux4_arbiter #(.BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int n_fail;

    // Behavioural model state
    int m_ptr;
    int m_valid;
    int m_out;
    int m_sel;
    int m_cnt;
    int lane [4];
    int last_gnt_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane index the model would grant this cycle, or -1
    function automatic int model_pick(input logic [3:0] rq, input logic rdy, input logic r);
        int k;
        if (r) return -1;
        if (!((m_valid == 0) || rdy)) return -1;
        for (int i = 0; i < 4; i++) begin
            k = (m_ptr + i) % 4;
            if (rq[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive_lanes();
        bus.in0 = 4'(lane[0]);
        bus.in1 = 4'(lane[1]);
        bus.in2 = 4'(lane[2]);
        bus.in3 = 4'(lane[3]);
    endtask

    // One clock: drive inputs, check grant, advance model, check registered outputs
    task automatic step(input logic r, input logic [3:0] rq, input logic rdy);
        int pick;
        logic [3:0] exp_gnt;
        @(negedge clk);
        reset         = r;
        bus.req       = rq;
        bus.out_ready = rdy;
        drive_lanes();
        #1;
        pick    = model_pick(rq, rdy, r);
        exp_gnt = (pick < 0) ? 4'b0000 : 4'(1 << pick);
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        last_gnt_idx = pick;
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_valid = 0; m_out = 0; m_sel = 0; m_cnt = 0;
        end else begin
            if (m_valid != 0 && rdy) m_cnt = (m_cnt + 1) % 256;
            if (pick >= 0) begin
                m_out   = lane[pick];
                m_sel   = pick;
                m_valid = 1;
                m_ptr   = (pick + 1) % 4;
            end else if (m_valid != 0 && rdy) begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out", 32'(bus.out), 32'(m_out));
        check("sel", 32'(bus.sel), 32'(m_sel));
        check("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
    endtask

    int exp_seq [5];
    logic [3:0] rq_r;
    logic [3:0] prev_req;
    int prev_pick;

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        m_ptr = 0; m_valid = 0; m_out = 0; m_sel = 0; m_cnt = 0;
        lane[0] = 5; lane[1] = 3; lane[2] = 0; lane[3] = 1;
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.out_ready = 1'b0;
        drive_lanes();

        // Reset state
        step(1'b1, 4'b0000, 1'b0);
        check("reset_out_zero", 32'(bus.out), 32'd0);

        // 1: all lanes requesting, consumer always ready
        exp_seq[0] = 5; exp_seq[1] = 3; exp_seq[2] = 0; exp_seq[3] = 1; exp_seq[4] = 5;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            check("rr_seq_out", 32'(bus.out), 32'(exp_seq[i]));
        end

        // 2: backpressure hold, then drain
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        check("bp_single_xfer", 32'(bus.xfer_cnt), 32'd1);
        check("bp_idle", 32'(bus.out_valid), 32'd0);
        step(1'b0, 4'b0000, 1'b1);

        // 3: wrap-around after lane 3
        step(1'b0, 4'b1000, 1'b1);
        step(1'b0, 4'b1001, 1'b1);
        check("wrap_lane0", 32'(bus.out), 32'd5);
        step(1'b0, 4'b1001, 1'b1);
        check("wrap_lane3", 32'(bus.out), 32'd1);

        // 4: skip fairness from ptr=1
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0101, 1'b1);
        check("skip_lane2", 32'(bus.sel), 32'd2);
        step(1'b0, 4'b0101, 1'b1);
        check("skip_lane0", 32'(bus.sel), 32'd0);

        // 5: reset while holding a word
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        check("mid_reset_cnt", 32'(bus.xfer_cnt), 32'd0);
        step(1'b0, 4'b1000, 1'b1);
        check("post_reset_sel", 32'(bus.sel), 32'd3);

        // 6: counter wrap over 256 transfers
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 1'b1);
        for (int i = 0; i < 256; i++) step(1'b0, 4'b0001, 1'b1);
        check("cnt_wrap", 32'(bus.xfer_cnt), 32'd0);
        check("cnt_wrap_out", 32'(bus.out), 32'd5);

        // Randomized traffic; a waiting lane keeps its word until granted
        prev_req  = 4'b0000;
        prev_pick = -1;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!(prev_req[k] && prev_pick != k)) lane[k] = int'($urandom_range(0, 15));
            end
            rq_r = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 49) == 0), rq_r, 1'($urandom_range(0, 1)));
            prev_req  = rq_r;
            prev_pick = last_gnt_idx;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter and sequencer for the 4:1 BIT-wide selection datapath (mux4 style).
- Four requesters each present a data word plus a req line.
- The block picks one requester per cycle and drives the select.
- It registers the selected word into a one-deep output stage with a valid/ready handshake.
- It sits between the producer lanes and a single downstream consumer that shares the datapath.

Parameters:
BIT, 4, data width of each input lane and of the output word.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  per-lane request; req[k] means in_k holds a valid word
in0  input  BIT  lane 0 data
in1  input  BIT  lane 1 data
in2  input  BIT  lane 2 data
in3  input  BIT  lane 3 data
gnt  output  4  one-hot grant, combinational; gnt[k]=1 means in_k is consumed at this clock edge
sel  output  2  registered index of the lane currently held in the output stage
out  output  BIT  registered output word
out_valid  output  1  output stage holds a word
out_ready  input  1  consumer accepts out when out_valid && out_ready at clock edge
xfer_cnt  output  8  count of completed output transfers, wraps 255->0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: out_valid=0, out=0, sel=0, xfer_cnt=0, internal pointer ptr=0, state IDLE. gnt is forced to 4'b0000 while reset=1.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- Accept condition: can_take = (!out_valid || out_ready) && |req && !reset.
- Grant selection:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first k with req[k]=1 gets gnt[k]=1 when can_take; otherwise gnt=0.
  - Exactly zero or one gnt bit is ever high.
- On a clock edge with gnt[k]=1:
  - out <= in_k, sel <= k, out_valid <= 1, ptr <= (k+1) mod 4 (k=3 wraps ptr to 0).
  - Next state is HOLD.
- Transfer: on a clock edge with out_valid && out_ready, xfer_cnt <= xfer_cnt+1 (mod 256).
- HOLD with out_ready=0:
  - out, sel and out_valid are held stable; gnt=0; ptr unchanged.
  - req changes have no effect on held data.
- HOLD with out_ready=1 and |req: back-to-back operation.
  - The new grant and the output load occur in the same cycle as the transfer.
  - Throughput is 1 word/cycle.
- HOLD with out_ready=1 and req=0: out_valid <= 0, go to IDLE. out and sel keep their last values.
- Latency: a req granted at edge N appears on out/out_valid after edge N (one cycle).
- Requester contract:
  - A word is consumed only at an edge where req[k]&&gnt[k].
  - The requester must hold in_k stable while req[k]=1 and gnt[k]=0.
- Fairness: a continuously requesting lane waits at most 3 grants to other lanes.
- Reset mid-operation: a held word is discarded (no transfer counted); all state returns to reset values on the next edge.
- No X propagation: out stays 0 until the first grant.

Test Plan:
1. Setup: in0=4'h5, in1=4'h3, in2=4'h0, in3=4'h1, reset 1 cycle, then req=4'b1111, out_ready=1 -> gnt sequence 0001,0010,0100,1000,0001; out 5,3,0,1,5; sel 0,1,2,3,0; out_valid=1 continuously; xfer_cnt increments each cycle.
2. Backpressure: req=4'b0010, out_ready=0 -> gnt=0010 one cycle, then out=3, sel=1, out_valid=1 held with gnt=0000 for 5 cycles. Drop req, raise out_ready -> transfer counted (xfer_cnt=1), out_valid=0 next cycle, state IDLE.
3. Wrap-around: after a grant to lane 3 (ptr=0), req=4'b1001 with out_ready=1 -> grants lane 0 (out=5) then lane 3 (out=1).
4. Skip fairness: with ptr=1 (after lane-0 grant), req=4'b0101 -> grants lane 2 (out=0) then lane 0 (out=5); lane 1 and lane 3 never granted.
5. Reset mid-hold: out_valid=1, out_ready=0, assert reset one cycle -> out_valid=0, out=0, sel=0, xfer_cnt=0, gnt=0000 during reset. After release, req=4'b1000 -> gnt=1000, out=1, sel=3.
6. Counter wrap: 256 back-to-back transfers with req=4'b0001, out_ready=1 -> xfer_cnt returns to 0; out=5 throughout.
